// File: rtl/rom_rr_nch_if.sv
// rom_rr_nch_if - request/response bundle for the N-channel round-robin ROM.
//
// Signals (named from the ROM's point of view):
//   i_en     arbiter enable; when low, no new reads are issued
//   i_req    per-channel read request
//   i_addr   packed per-channel addresses, channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//   o_valid  per-channel one-cycle pulse: that channel's o_data slice was updated
//   o_data   packed per-channel read data, held between updates
//   o_pend   channel has an accepted request that has not been issued yet
//   o_ovf    sticky per-channel flag: a request was dropped while still pending
//
// Modports: master (index generators / bench), slave (the ROM).

interface rom_rr_nch_if #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                      i_en;
    logic [NCH-1:0]            i_req;
    logic [NCH*ADDR_WIDTH-1:0] i_addr;
    logic [NCH-1:0]            o_valid;
    logic [NCH*DATA_WIDTH-1:0] o_data;
    logic [NCH-1:0]            o_pend;
    logic [NCH-1:0]            o_ovf;

    modport master (
        output i_en, i_req, i_addr,
        input  o_valid, o_data, o_pend, o_ovf
    );

    modport slave (
        input  i_en, i_req, i_addr,
        output o_valid, o_data, o_pend, o_ovf
    );
endinterface

// File: rtl/rom_rr_nch.sv
// rom_rr_nch - N-channel read-only lookup table behind one registered read port.
//
// Channels post requests which are held as pending, then granted one per cycle in
// round-robin order starting at the channel after the last one served. The single
// synchronous read maps onto one block RAM. Request to o_valid latency is 2 cycles.
//
// Ports:
//   i_clk   system clock
//   i_rst   asynchronous, active-high reset
//   io_bus  rom_rr_nch_if.slave (i_en, i_req, i_addr, o_valid, o_data, o_pend, o_ovf)
//
// Build option: define ROM_RR_NCH_QUARTER_WAVE_EN to store only the first quarter of a
// signed period (depth 1<<(ADDR_WIDTH-2)); the other quarters are rebuilt by mirroring
// the index and negating the word in the output stage.

module rom_rr_nch #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 8,
    parameter string       LOAD_PATH  = ""
) (
    input logic             i_clk,
    input logic             i_rst,
    rom_rr_nch_if.slave     io_bus
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef ROM_RR_NCH_QUARTER_WAVE_EN
    localparam int unsigned MW = ADDR_WIDTH - 2;
`else
    localparam int unsigned MW = ADDR_WIDTH;
`endif
    localparam int unsigned DEPTH = 1 << MW;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [NCH-1:0]            r_pend;
    logic [ADDR_WIDTH-1:0]     r_addr [NCH];
    logic [NCH-1:0]            r_ovf;
    logic [PW-1:0]             r_ptr;
    logic                      r_rvld;
    logic [PW-1:0]             r_tag;
    logic [DATA_WIDTH-1:0]     r_rd;
    logic [NCH-1:0]            r_valid;
    logic [NCH*DATA_WIDTH-1:0] r_data;

    logic                      w_gnt_vld;
    logic [PW-1:0]             w_gnt;
    logic [NCH-1:0]            w_gnt_oh;
    logic [PW-1:0]             w_ptr_nxt;
    logic [ADDR_WIDTH-1:0]     w_raddr;
    logic [MW-1:0]             w_ridx;
    logic [DATA_WIDTH-1:0]     w_out;

    // First pending channel at or after r_ptr, wrapping modulo NCH. Walking the
    // offsets downward lets the smallest offset overwrite the result last.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            int unsigned v_idx;
            v_idx = int'(r_ptr) + i;
            if (v_idx >= NCH) begin
                v_idx = v_idx - NCH;
            end
            if (io_bus.i_en && r_pend[v_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = PW'(v_idx);
            end
        end
    end

    assign w_gnt_oh  = w_gnt_vld ? (NCH'(1) << w_gnt) : '0;
    assign w_ptr_nxt = (w_gnt == PW'(NCH - 1)) ? '0 : w_gnt + 1'b1;
    assign w_raddr   = r_addr[w_gnt];

`ifdef ROM_RR_NCH_QUARTER_WAVE_EN
    logic r_neg;
    logic w_rneg;

    // Second and fourth quarters read the table backwards.
    assign w_ridx = w_raddr[ADDR_WIDTH-3:0] ^ {(ADDR_WIDTH-2){w_raddr[ADDR_WIDTH-2]}};
    assign w_rneg = w_raddr[ADDR_WIDTH-1];

    // Negative half: two's-complement negate, with the most negative word clamped to +max.
    always_comb begin
        w_out = r_rd;
        if (r_neg) begin
            if (r_rd == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
                w_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end else begin
                w_out = -r_rd;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_gnt_vld) begin
            r_neg <= w_rneg;
        end
    end
`else
    assign w_ridx = w_raddr;
    assign w_out  = r_rd;
`endif

    // Read port kept free of reset so it maps onto block RAM; r_rvld qualifies it.
    always_ff @(posedge i_clk) begin
        if (w_gnt_vld) begin
            r_rd  <= r_mem[w_ridx];
            r_tag <= w_gnt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend  <= '0;
            r_ovf   <= '0;
            r_ptr   <= '0;
            r_rvld  <= 1'b0;
            r_valid <= '0;
            r_data  <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_addr[c] <= '0;
            end
        end else begin
            // A channel being granted this cycle frees its slot, so a new request
            // on the same edge is accepted rather than flagged as overflow.
            for (int c = 0; c < NCH; c++) begin
                if (io_bus.i_req[c] && (!r_pend[c] || w_gnt_oh[c])) begin
                    r_addr[c] <= io_bus.i_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                    r_pend[c] <= 1'b1;
                end else if (io_bus.i_req[c]) begin
                    r_ovf[c] <= 1'b1;
                end else if (w_gnt_oh[c]) begin
                    r_pend[c] <= 1'b0;
                end
            end

            r_rvld <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_ptr <= w_ptr_nxt;
            end

            if (r_rvld) begin
                r_data[int'(r_tag)*DATA_WIDTH +: DATA_WIDTH] <= w_out;
                r_valid <= NCH'(1) << r_tag;
            end else begin
                r_valid <= '0;
            end
        end
    end

    assign io_bus.o_valid = r_valid;
    assign io_bus.o_data  = r_data;
    assign io_bus.o_pend  = r_pend;
    assign io_bus.o_ovf   = r_ovf;

endmodule

// File: tb/tb_rom_rr_nch.sv
// tb_rom_rr_nch - directed bench for rom_rr_nch (NCH=4, ADDR_WIDTH=9, DATA_WIDTH=8).
// The table is preloaded with mem[k] = k. With ROM_RR_NCH_QUARTER_WAVE_EN defined the
// same sequence runs against a 128-entry quarter table plus a mirrored/negated read set.

module tb_rom_rr_nch;

    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 9;
    localparam int unsigned DW  = 8;
`ifdef ROM_RR_NCH_QUARTER_WAVE_EN
    localparam int unsigned DEPTH = 1 << (AW - 2);
`else
    localparam int unsigned DEPTH = 1 << AW;
`endif

    logic r_clk;
    logic r_rst;
    int   n_assert;
    int   n_fail;

    rom_rr_nch_if #(.NCH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rom_rr_nch #(
        .NCH        (NCH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LOAD_PATH  ("")
    ) dut (
        .i_clk  (r_clk),
        .i_rst  (r_rst),
        .io_bus (bus)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move 1 time unit past it to drive and sample.
    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic set_addr(input int c, input logic [AW-1:0] a);
        bus.i_addr[c*AW +: AW] = a;
    endtask

    task automatic pulse_reset();
        r_rst = 1'b1;
        step();
        r_rst = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int k = 0; k < DEPTH; k++) begin
            dut.r_mem[k] = DW'(k);
        end
        r_rst      = 1'b1;
        bus.i_en   = 1'b0;
        bus.i_req  = '0;
        bus.i_addr = '0;
        step();
        step();
        check("rst_valid", 32'(bus.o_valid), 32'h0);
        check("rst_data",  bus.o_data,       32'h0);
        check("rst_pend",  32'(bus.o_pend),  32'h0);
        check("rst_ovf",   32'(bus.o_ovf),   32'h0);
        r_rst = 1'b0;

        // Single request on channel 0.
        bus.i_en  = 1'b1;
        bus.i_req = 4'b0001;
        set_addr(0, 9'h005);
        step();
        bus.i_req = '0;
        check("single_pend_e0",  32'(bus.o_pend),  32'h1);
        check("single_valid_e0", 32'(bus.o_valid), 32'h0);
        step();
        check("single_pend_e1",  32'(bus.o_pend),  32'h0);
        check("single_valid_e1", 32'(bus.o_valid), 32'h0);
        step();
        check("single_valid_e2", 32'(bus.o_valid), 32'h1);
        check("single_data_e2",  bus.o_data,       32'h0000_0005);
        step();
        check("single_valid_e3", 32'(bus.o_valid), 32'h0);

        // All channels in one cycle, from a fresh pointer of 0.
        pulse_reset();
        bus.i_req = 4'b1111;
        set_addr(0, 9'h010);
        set_addr(1, 9'h011);
        set_addr(2, 9'h012);
        set_addr(3, 9'h013);
        step();
        bus.i_req = '0;
        check("all_pend", 32'(bus.o_pend), 32'hF);
        step();
        step();
        check("all_valid0", 32'(bus.o_valid), 32'h1);
        check("all_data0",  bus.o_data,       32'h0000_0010);
        step();
        check("all_valid1", 32'(bus.o_valid), 32'h2);
        check("all_data1",  bus.o_data,       32'h0000_1110);
        step();
        check("all_valid2", 32'(bus.o_valid), 32'h4);
        check("all_data2",  bus.o_data,       32'h0012_1110);
        step();
        check("all_valid3", 32'(bus.o_valid), 32'h8);
        check("all_data3",  bus.o_data,       32'h1312_1110);
        step();
        check("all_valid_end", 32'(bus.o_valid), 32'h0);

        // Overflow while the arbiter is disabled; ptr is 0 after serving channel 3.
        bus.i_en  = 1'b0;
        bus.i_req = 4'b0100;
        set_addr(2, 9'h020);
        step();
        set_addr(2, 9'h021);
        step();
        bus.i_req = '0;
        check("ovf_flag",  32'(bus.o_ovf),   32'h4);
        check("ovf_pend",  32'(bus.o_pend),  32'h4);
        step();
        step();
        check("ovf_hold_pend",  32'(bus.o_pend),  32'h4);
        check("ovf_hold_valid", 32'(bus.o_valid), 32'h0);
        bus.i_en = 1'b1;
        step();
        step();
        check("ovf_valid", 32'(bus.o_valid), 32'h4);
        check("ovf_data",  bus.o_data,       32'h1320_1110);
        check("ovf_pend_clr", 32'(bus.o_pend), 32'h0);
        check("ovf_sticky",   32'(bus.o_ovf),  32'h4);

        // Grant and new request on the same channel in the same cycle.
        bus.i_req = 4'b0010;
        set_addr(1, 9'h030);
        step();
        set_addr(1, 9'h031);
        step();
        bus.i_req = '0;
        check("sim_pend",    32'(bus.o_pend), 32'h2);
        check("sim_no_ovf",  32'(bus.o_ovf),  32'h4);
        step();
        check("sim_valid_a", 32'(bus.o_valid), 32'h2);
        check("sim_data_a",  bus.o_data,       32'h1320_3010);
        step();
        check("sim_valid_b", 32'(bus.o_valid), 32'h2);
        check("sim_data_b",  bus.o_data,       32'h1320_3110);

        // Reset asserted right after a grant: the in-flight read never appears.
        bus.i_req = 4'b0001;
        set_addr(0, 9'h044);
        step();
        bus.i_req = '0;
        step();
        r_rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.o_valid), 32'h0);
        check("midrst_data",  bus.o_data,       32'h0);
        check("midrst_ovf",   32'(bus.o_ovf),   32'h0);
        check("midrst_pend",  32'(bus.o_pend),  32'h0);
        step();
        r_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_quiet", 32'(bus.o_valid), 32'h0);
        end

        // Top of the address range on channel 3 (ptr is 0 after reset).
        bus.i_req = 4'b1000;
        set_addr(3, 9'h1FF);
        step();
        bus.i_req = '0;
        step();
        step();
        check("top_valid", 32'(bus.o_valid), 32'h8);
`ifdef ROM_RR_NCH_QUARTER_WAVE_EN
        // 0x1FF mirrors to index 0 (word 0) and negates to 0.
        check("top_data", bus.o_data, 32'h0000_0000);
`else
        check("top_data", bus.o_data, 32'hFF00_0000);
`endif

`ifdef ROM_RR_NCH_QUARTER_WAVE_EN
        // 0x005 -> 0x05; 0x1FA -> -(q[0x05]) = 0xFB; 0x080 -> q[0x7F]; 0x180 -> -(0x7F) = 0x81.
        pulse_reset();
        bus.i_req = 4'b1111;
        set_addr(0, 9'h005);
        set_addr(1, 9'h1FA);
        set_addr(2, 9'h080);
        set_addr(3, 9'h180);
        step();
        bus.i_req = '0;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("qw_valid", 32'(bus.o_valid), 32'h8);
        check("qw_data",  bus.o_data,       32'h817F_FB05);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
